// File: rtl/sum_latch_pkg.sv
// Shared types, parity modes and width helpers for the operand-sum UART transmitter.
package sum_latch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned BYTE_W   = 8;

    // Sum width grows by clog2 of the operand count so the adder never wraps.
    function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned num_ops);
        return data_w + $clog2(num_ops);
    endfunction

    function automatic int unsigned num_bytes(input int unsigned sum_w);
        return (sum_w + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/sum_latch_uart_tx_byte.sv
// Single-byte UART framer: start, 8 data bits LSB first, optional parity, stop.
// Chains straight into the next byte's start bit when last_byte is low.
module uart_tx_byte
    import sum_latch_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       last_byte,
    output logic       txd,
    output logic       busy,
    output logic       byte_done_c
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_e         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic              baud_end;
    logic              par_bit;

    assign baud_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign par_bit     = (PARITY == PAR_ODD) ? ~(^data) : (^data);
    assign byte_done_c = (state == ST_STOP) && baud_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            // Baud counter restarts at every bit boundary and rests at zero when idle.
            if (state == ST_IDLE || baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_START;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        txd     <= data[0];
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= data[bit_cnt + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_end) begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        if (last_byte) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_START;
                            txd   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches NUM_OPS operands, keeps a registered running sum and, on request,
// ships a snapshot of that sum over UART as NBYTES little-endian bytes.
module sum_latch_uart_tx
    import sum_latch_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned NUM_OPS      = 2,
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY       = 0,
    localparam int unsigned SUM_W       = sum_width(DATA_W, NUM_OPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [NUM_OPS-1:0] save,
    input  logic               send,
    output logic [SUM_W-1:0]   sum_out,
    output logic               uart_txd,
    output logic               uart_tx_busy
);

    localparam int unsigned NBYTES = num_bytes(SUM_W);
    localparam int unsigned BUF_W  = NBYTES * BYTE_W;
    localparam int unsigned BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_W-1:0] ops [NUM_OPS];
    logic [SUM_W-1:0]  sum_c;
    logic [BUF_W-1:0]  shift_buf;
    logic [BCNT_W-1:0] byte_cnt;
    logic              accept_c;
    logic              last_byte_c;
    logic              byte_done_c;

    // Operand capture runs in every state; a frame in flight reads only shift_buf.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                ops[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (save[i]) begin
                    ops[i] <= data_in;
                end
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            sum_c = sum_c + SUM_W'(ops[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_out <= '0;
        end else begin
            sum_out <= sum_c;
        end
    end

    assign accept_c    = send && !uart_tx_busy;
    assign last_byte_c = (byte_cnt == BCNT_W'(NBYTES - 1));

    // Snapshot takes the pre-edge sum; the low byte of shift_buf always feeds the framer.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_buf <= '0;
            byte_cnt  <= '0;
        end else if (accept_c) begin
            shift_buf <= BUF_W'(sum_out);
            byte_cnt  <= '0;
        end else if (byte_done_c) begin
            if (last_byte_c) begin
                byte_cnt <= '0;
            end else begin
                shift_buf <= shift_buf >> BYTE_W;
                byte_cnt  <= byte_cnt + BCNT_W'(1);
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY       (PARITY)
    ) u_tx_byte (
        .clk         (clk),
        .reset       (reset),
        .start       (accept_c),
        .data        (shift_buf[7:0]),
        .last_byte   (last_byte_c),
        .txd         (uart_txd),
        .busy        (uart_tx_busy),
        .byte_done_c (byte_done_c)
    );

endmodule
